// File: rtl/conv_frame_sequencer.sv
// Sequences one raster-order pixel frame through the 3x3 conv datapath.
// Ports: ACLK/ARESETN; start + cfg_width/cfg_height from the register
// block; in_valid/in_ready pixel handshake; win_valid/win_ready window
// strobe with win_row/win_col centre and win_last; busy/done/err_cfg.
module conv_frame_sequencer #(
  parameter int DIM_W  = 12,
  parameter int KERNEL = 3
) (
  input  logic             ACLK,
  input  logic             ARESETN,
  input  logic             start,
  input  logic [DIM_W-1:0] cfg_width,
  input  logic [DIM_W-1:0] cfg_height,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             win_valid,
  input  logic             win_ready,
  output logic [DIM_W-1:0] win_row,
  output logic [DIM_W-1:0] win_col,
  output logic             win_last,
  output logic             busy,
  output logic             done,
  output logic             err_cfg
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [DIM_W-1:0] K_MIN = DIM_W'(KERNEL);
  localparam logic [DIM_W-1:0] EDGE  = DIM_W'(KERNEL - 1);
  localparam logic [DIM_W-1:0] ONE   = DIM_W'(1);

  logic [1:0]       state;
  logic [DIM_W-1:0] width;
  logic [DIM_W-1:0] height;
  logic [DIM_W-1:0] col;
  logic [DIM_W-1:0] row;

  logic cfg_ok;
  logic accept;
  logic col_end;
  logic row_end;
  logic win_hit;
  logic out_fire;

  assign cfg_ok   = (cfg_width >= K_MIN) && (cfg_height >= K_MIN);
  // single output register without skid: a stalled window blocks input
  assign in_ready = (state == S_RUN) && (!win_valid || win_ready);
  assign accept   = in_valid && in_ready;
  assign col_end  = (col == width - ONE);
  assign row_end  = (row == height - ONE);
  assign win_hit  = (row >= EDGE) && (col >= EDGE);
  assign out_fire = win_valid && win_ready;
  assign busy     = (state == S_RUN) || (state == S_FLUSH);
  assign done     = (state == S_DONE);

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state     <= S_IDLE;
      width     <= '0;
      height    <= '0;
      col       <= '0;
      row       <= '0;
      err_cfg   <= 1'b0;
      win_valid <= 1'b0;
      win_row   <= '0;
      win_col   <= '0;
      win_last  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            if (cfg_ok) begin
              width   <= cfg_width;
              height  <= cfg_height;
              col     <= '0;
              row     <= '0;
              err_cfg <= 1'b0;
              state   <= S_RUN;
            end else begin
              err_cfg <= 1'b1;
              state   <= S_DONE;
            end
          end
        end
        S_RUN: begin
          if (accept) begin
            if (col_end) begin
              col <= '0;
              row <= row + ONE;
            end else begin
              col <= col + ONE;
            end
            if (col_end && row_end) begin
              state <= S_FLUSH;
            end
          end
        end
        S_FLUSH: begin
          if (out_fire && win_last) begin
            state <= S_DONE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase

      // a load in the same cycle as a handshake replaces the contents
      if (accept && win_hit) begin
        win_valid <= 1'b1;
        win_row   <= row - ONE;
        win_col   <= col - ONE;
        win_last  <= col_end && row_end;
      end else if (out_fire) begin
        win_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/conv_frame_sequencer.md
# conv_frame_sequencer

Sequences one frame of raster-order pixels through the 3x3 convolution datapath behind the AXI convolution controller. The AXI-lite register block supplies frame geometry and a start pulse. This block accepts the pixel stream and tracks row/column position. It issues one window-fire strobe to the MAC datapath for every position where a full 3x3 neighbourhood is available, and reports busy/done/error back to the register block.

## Interface
- DIM_W, 12: width of geometry and coordinate fields; max frame 4095x4095.
- KERNEL, 3: kernel edge length. Only 3 is supported; windows start at row/col KERNEL-1.

- ACLK  in  1  single clock for the block.
- ARESETN  in  1  reset, synchronous and active-low, sampled on rising ACLK.
- start  in  1  one-cycle pulse from the register block; ignored unless state is IDLE.
- cfg_width  in  DIM_W  frame width in pixels; latched on accepted start.
- cfg_height  in  DIM_W  frame height in pixels; latched on accepted start.
- in_valid  in  1  pixel stream valid; the pixel data itself bypasses this block.
- in_ready  out  1  pixel accepted when in_valid && in_ready.
- win_valid  out  1  a 3x3 window is complete; MAC datapath should fire.
- win_ready  in  1  MAC datapath accepts the window when win_valid && win_ready.
- win_row  out  DIM_W  centre row of the current window.
- win_col  out  DIM_W  centre column of the current window.
- win_last  out  1  qualifies the final window of the frame.
- busy  out  1  high in RUN and FLUSH.
- done  out  1  one-cycle pulse at end of frame or on rejected config.
- err_cfg  out  1  sticky; set when a start carries width<3 or height<3; cleared by the next accepted start.

## Operation
- FSM states: IDLE, RUN, FLUSH, DONE.
- IDLE -> RUN: start with cfg_width>=3 and cfg_height>=3. Latch geometry, clear col/row counters, clear err_cfg.
- IDLE -> DONE: start with an invalid geometry. Set err_cfg. No pixels are accepted.
- RUN: in_ready = !win_valid || win_ready (single output register, no skid).
  - On each accepted pixel, col increments. At col==width-1, col wraps to 0 and row increments.
  - When the accepted pixel is at (row>=2, col>=2), load the output register: win_valid=1, win_row=row-1, win_col=col-1, win_last = (row==height-1 && col==width-1).
- RUN -> FLUSH: accept the pixel at (height-1, width-1). Then in_ready=0.
- FLUSH -> DONE: win_valid && win_ready && win_last.
- DONE -> IDLE: unconditional after one cycle; done=1 only in DONE.
- win_valid holds, with win_row/win_col/win_last stable, until win_ready is seen.
- A simultaneous output handshake and new load in the same cycle is legal and replaces the register contents.
- Counter arithmetic is unsigned DIM_W bits; no pixel beyond width*height is ever accepted.
- start during RUN, FLUSH or DONE has no effect; geometry inputs may change freely after being latched.

## Timing
- Reset values: in_ready=0, win_valid=0, win_row=0, win_col=0, win_last=0, busy=0, done=0, err_cfg=0, state=IDLE.
- ARESETN low at any point, including mid-frame, returns the block to IDLE within that edge. The partial frame is discarded and no done pulse is issued.
- start at edge N -> busy=1 and in_ready=1 from edge N+1 (valid cfg). Invalid cfg -> done=1 and err_cfg=1 at edge N+1; busy stays 0.
- Window latency: pixel accepted at edge N -> win_valid=1 after edge N.
- Final window handshake at edge N -> done=1 during cycle N+1. busy=0 and state=IDLE from edge N+2.
- in_ready is combinational from win_valid/win_ready and state only; it never depends on in_valid.

## Test plan
- 4x4 frame, in_valid and win_ready held 1 -> exactly 4 windows, centres (1,1),(1,2),(2,1),(2,2); win_last only on (2,2); single done pulse; 16 pixels accepted.
- 3x3 frame -> exactly 1 window at (1,1) with win_last=1; done 1 cycle after its handshake.
- 5x4 frame, win_ready low for 3 cycles on window (1,2) -> in_ready=0 during the stall; window fields held; no window lost or duplicated; 6 windows total.
- start with width=2, height=8 -> err_cfg=1 and done pulse at N+1; in_ready never 1. A following valid 3x3 start clears err_cfg.
- ARESETN=0 after 7 pixels of a 4x4 frame -> all outputs at reset values, no done pulse. A new start runs a clean 4-window frame.
- start pulsed during RUN with different geometry -> ignored; the frame completes with the original geometry.
